mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single MemoryBus port between the pipeline stages that issue memory traffic: fetch (instruction reads), load (data reads) and store (data writes).
- Round-robin arbitration with at most one transaction outstanding on the memory side.
- Tags each issued request with the requester's bus ID.
- Routes the matching memory response back to the winning requester only.

Parameters:
- NUM_REQ, 3, number of requesters (index 0 = fetch, 1 = load, 2 = store).
- ADDR_W, 64, memory_address_t width.
- DATA_W, 64, payload width (one fetched_instruction_data_t / uint64_t).
- ID_W, 4, BusID width.
- ID_BASE, 1, BusID assigned to requester 0; requester i uses ID_BASE+i.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  per-requester address (low 3 bits ignored; issued 8-byte aligned).
- req_wdata  in  NUM_REQ*DATA_W  per-requester write data.
- req_ready  out  NUM_REQ  one-hot accept strobe.
- resp_valid  out  NUM_REQ  one-hot response strobe.
- resp_data  out  DATA_W  response payload, shared across requesters.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_req_write  out  1  write flag.
- mem_req_addr  out  ADDR_W  aligned address.
- mem_req_wdata  out  DATA_W  write data.
- mem_req_id  out  ID_W  tag.
- mem_resp_valid  in  1  response present (bus_read_response or write ack).
- mem_resp_id  in  ID_W  response tag.
- mem_resp_data  in  DATA_W  response payload.
- protocol_err  out  1  sticky error flag.
- stat_wait_cnt  out  NUM_REQ*32  per-requester wait counters.

Behaviour:
- Reset (asynchronous, reset_n low): state IDLE, rr_ptr=0, all outputs 0, latched request cleared. Reset mid-transaction abandons the transaction; no response is delivered for it.
- IDLE:
  - Winner = first index with req_valid set, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[winner]=1 combinationally in the same cycle.
  - Winner's write flag, aligned address (addr & ~7), wdata and ID are latched.
  - Next state ISSUE. With no req_valid set, stay in IDLE.
- ISSUE: mem_req_* driven from the latched request; mem_req_valid held at 1 until mem_req_ready=1, then next state WAIT.
- WAIT:
  - On mem_resp_valid with mem_resp_id == latched ID: register mem_resp_data into resp_data and next state DELIVER.
  - On mem_resp_valid with a mismatched ID: set protocol_err, drop the response, stay in WAIT.
- DELIVER:
  - resp_valid[winner]=1 for exactly one cycle; resp_data is valid in that cycle.
  - Write acks also pulse resp_valid, with resp_data = mem_resp_data.
  - rr_ptr = (winner+1) mod NUM_REQ; next state IDLE.
- Latency: accept at T, mem_req_valid at T+1. With memory ready at T+1 and responding at T+R, resp_valid asserts at T+R+1. Minimum request-to-request spacing is 4 cycles.
- req_ready is never asserted outside IDLE. Requesters must hold valid and payload stable until req_ready.
- mem_resp_valid arriving in IDLE, ISSUE or DELIVER: set protocol_err and ignore the response.
- protocol_err clears only on reset.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- With it: stat_wait_cnt[i] increments each cycle that req_valid[i]=1 and req_ready[i]=0. Counters are 32-bit, saturate at 0xFFFFFFFF and reset to 0.
- Without it: counter logic is absent and stat_wait_cnt is tied to 0. Arbitration behaviour is identical in both builds.

Decomposition:
- Package mem_arb_pkg holds:
  - arb_state_t enum {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_DELIVER};
  - localparams REQ_FETCH=0, REQ_LOAD=1, REQ_STORE=2;
  - ALIGN_MASK = ~64'h7.
- One sub-module: rr_picker. Inputs are a request vector and rr_ptr; outputs are a one-hot grant and the grant index. It is purely combinational.

Test Plan:
- Fetch-only read: req_valid=3'b001, addr=0x1004; memory ready immediately and responds after 2 cycles with 0xDEADBEEF_00000013 -> mem_req_addr=0x1000, mem_req_id=1, resp_valid=3'b001 with that data, protocol_err=0.
- All three requesters held valid continuously from reset -> grants in order fetch, load, store, fetch, each accepted exactly once per rotation.
- Store write: addr 0x2000, wdata 0x55; mem_req_ready held low 5 cycles -> mem_req_valid, addr and wdata stable for all 6 cycles; ack delivered as resp_valid=3'b100 only.
- While waiting on ID 2, memory returns ID 3 then ID 2 -> protocol_err=1 after the first response; the ID 2 payload is delivered to load only.
- reset_n pulsed low during WAIT, then a late response arrives -> all outputs 0 during reset, no resp_valid afterwards, the late response sets protocol_err, rr_ptr=0.
- MEM_ARB_STATS_EN build: load held valid 7 cycles while fetch's transaction completes -> stat_wait_cnt[1]=7 at grant; non-stats build reads 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arb_pkg : shared types and constants for mem_bus_arbiter  rev 1.0 |
// +----------------------------------------------------------------------+
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ISSUE   = 2'd1,
    ARB_WAIT    = 2'd2,
    ARB_DELIVER = 2'd3
  } arb_state_t;

  localparam int REQ_FETCH = 0;
  localparam int REQ_LOAD  = 1;
  localparam int REQ_STORE = 2;

  localparam logic [63:0] ALIGN_MASK = ~64'h7;

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_picker : combinational round-robin grant from a pointer   rev 1.0 |
// +----------------------------------------------------------------------+
module rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic found;
  int   idx;

  // Scan ptr, ptr+1, ... wrapping; the first set request wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_bus_arbiter : round-robin sharing of one MemoryBus port  rev 1.0  |
// | Define MEM_ARB_STATS_EN to build the per-requester wait counters.     |
// +----------------------------------------------------------------------+
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int ID_W    = 4,
  parameter int ID_BASE = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_req_write,
  output logic [ADDR_W-1:0]         mem_req_addr,
  output logic [DATA_W-1:0]         mem_req_wdata,
  output logic [ID_W-1:0]           mem_req_id,
  input  logic                      mem_resp_valid,
  input  logic [ID_W-1:0]           mem_resp_id,
  input  logic [DATA_W-1:0]         mem_resp_data,
  output logic                      protocol_err,
  output logic [NUM_REQ*32-1:0]     stat_wait_cnt
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t          state, state_nxt;
  logic [IDX_W-1:0]    rr_ptr, win_idx, pick_idx;
  logic [NUM_REQ-1:0]  pick_grant;
  logic                accept, resp_match;
  logic                lat_write;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [ID_W-1:0]     lat_id;
  logic [DATA_W-1:0]   resp_data_r;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (pick_grant),
    .grant_idx (pick_idx)
  );

  assign resp_match = (state == ARB_WAIT) && mem_resp_valid && (mem_resp_id == lat_id);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (|req_valid) begin
          accept    = 1'b1;
          state_nxt = ARB_ISSUE;
        end
      end
      ARB_ISSUE:   if (mem_req_ready) state_nxt = ARB_WAIT;
      ARB_WAIT:    if (resp_match) state_nxt = ARB_DELIVER;
      ARB_DELIVER: state_nxt = ARB_IDLE;
      default:     state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ARB_IDLE;
      rr_ptr       <= IDX_W'(REQ_FETCH);
      win_idx      <= '0;
      lat_write    <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_id       <= '0;
      resp_data_r  <= '0;
      protocol_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        win_idx   <= pick_idx;
        lat_write <= req_write[pick_idx];
        lat_addr  <= req_addr[int'(pick_idx)*ADDR_W +: ADDR_W] & ADDR_W'(ALIGN_MASK);
        lat_wdata <= req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
        lat_id    <= ID_W'(ID_BASE + int'(pick_idx));
      end
      if (resp_match) resp_data_r <= mem_resp_data;
      // Any response other than the one we are waiting for is dropped and flagged.
      if (mem_resp_valid && !resp_match) protocol_err <= 1'b1;
      if (state == ARB_DELIVER)
        rr_ptr <= (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
    end
  end

  // Gated by reset_n so a held request cannot see a grant while reset is low.
  assign req_ready     = (accept && reset_n) ? pick_grant : '0;
  assign resp_valid    = (state == ARB_DELIVER) ? (NUM_REQ'(1) << win_idx) : '0;
  assign resp_data     = resp_data_r;
  assign mem_req_valid = (state == ARB_ISSUE);
  assign mem_req_write = lat_write;
  assign mem_req_addr  = lat_addr;
  assign mem_req_wdata = lat_wdata;
  assign mem_req_id    = lat_id;

`ifdef MEM_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    logic [31:0] cnt;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt <= '0;
      end else if (req_valid[i] && !req_ready[i] && (cnt != 32'hFFFF_FFFF)) begin
        cnt <= cnt + 32'd1;
      end
    end
    assign stat_wait_cnt[i*32 +: 32] = cnt;
  end
`else
  assign stat_wait_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// tb_mem_bus_arbiter : directed scoreboard bench; a bench-side memory serves
// each request and expected bus/response traffic is queued as it is driven.
module tb_mem_bus_arbiter;

`ifdef MEM_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk;
  logic          reset_n;
  logic [2:0]    b_valid;
  logic [2:0]    b_wr;
  logic [63:0]   b_addr  [3];
  logic [63:0]   b_wdata [3];
  logic [191:0]  req_addr, req_wdata;
  logic [2:0]    req_ready, resp_valid;
  logic [63:0]   resp_data;
  logic          mem_req_valid, mem_req_ready, mem_req_write;
  logic [63:0]   mem_req_addr, mem_req_wdata;
  logic [3:0]    mem_req_id;
  logic          mem_resp_valid;
  logic [3:0]    mem_resp_id;
  logic [63:0]   mem_resp_data;
  logic          protocol_err;
  logic [95:0]   stat_wait_cnt;

  typedef struct {
    logic        w;
    logic [63:0] a;
    logic [63:0] d;
    logic [3:0]  id;
  } mem_exp_t;

  typedef struct {
    logic [2:0]  v;
    logic [63:0] d;
  } resp_exp_t;

  mem_exp_t  exp_mem[$];
  resp_exp_t exp_resp[$];
  mem_exp_t  cur, me;
  resp_exp_t re;
  int        errors = 0;
  int        checks = 0;

  assign req_addr  = {b_addr[2], b_addr[1], b_addr[0]};
  assign req_wdata = {b_wdata[2], b_wdata[1], b_wdata[0]};

  mem_bus_arbiter dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (b_valid),
    .req_write      (b_wr),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_ready      (req_ready),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_write  (mem_req_write),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_id     (mem_req_id),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_id    (mem_resp_id),
    .mem_resp_data  (mem_resp_data),
    .protocol_err   (protocol_err),
    .stat_wait_cnt  (stat_wait_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bus and response monitors pop the scoreboard whenever the DUT produces traffic.
  always @(negedge clk) begin
    if (mem_req_valid && mem_req_ready) begin
      if (exp_mem.size() == 0) chk("mem_unexpected", mem_req_valid, 0);
      else begin
        me = exp_mem.pop_front();
        chk("mem_write", mem_req_write, me.w);
        chk("mem_addr", mem_req_addr, me.a);
        chk("mem_wdata", mem_req_wdata, me.d);
        chk("mem_id", mem_req_id, me.id);
      end
    end
    if (resp_valid != 3'b000) begin
      if (exp_resp.size() == 0) chk("resp_unexpected", resp_valid, 0);
      else begin
        re = exp_resp.pop_front();
        chk("resp_vec", resp_valid, re.v);
        chk("resp_data", resp_data, re.d);
      end
    end
  end

  task automatic check_zero(string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_data"}, resp_data, 0);
    chk({tag, "_mem_valid"}, mem_req_valid, 0);
    chk({tag, "_mem_write"}, mem_req_write, 0);
    chk({tag, "_mem_addr"}, mem_req_addr, 0);
    chk({tag, "_mem_wdata"}, mem_req_wdata, 0);
    chk({tag, "_mem_id"}, mem_req_id, 0);
    chk({tag, "_perr"}, protocol_err, 0);
    chk({tag, "_stats"}, 64'(|stat_wait_cnt), 0);
  endtask

  task automatic wait_grant(logic [2:0] exp, string tag);
    int n;
    int idx;
    mem_exp_t e;
    n   = 0;
    idx = exp[1] ? 1 : (exp[2] ? 2 : 0);
    @(negedge clk);
    while (req_ready == 3'b000 && n < 20) begin
      step();
      @(negedge clk);
      n++;
    end
    chk(tag, req_ready, exp);
    e.w  = b_wr[idx];
    e.a  = b_addr[idx] & ~64'h7;
    e.d  = b_wdata[idx];
    e.id = 4'(1 + idx);
    exp_mem.push_back(e);
    cur = e;
  endtask

  // Called in the cycle after the grant; returns in the IDLE cycle after delivery.
  task automatic mem_serve(int ready_delay, int resp_delay, bit bad_first,
                           logic [3:0] id, logic [63:0] data, logic [2:0] vec);
    resp_exp_t r;
    for (int i = 0; i < ready_delay; i++) begin
      @(negedge clk);
      chk("stall_valid", mem_req_valid, 1);
      chk("stall_addr", mem_req_addr, cur.a);
      chk("stall_wdata", mem_req_wdata, cur.d);
      step();
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int i = 0; i < resp_delay; i++) step();
    if (bad_first) begin
      mem_resp_valid = 1'b1;
      mem_resp_id    = id + 4'd1;
      mem_resp_data  = ~data;
      step();
    end
    mem_resp_valid = 1'b1;
    mem_resp_id    = id;
    mem_resp_data  = data;
    r.v = vec;
    r.d = data;
    exp_resp.push_back(r);
    if (bad_first) begin
      @(negedge clk);
      chk("perr_on_bad_id", protocol_err, 1);
    end
    step();
    mem_resp_valid = 1'b0;
    mem_resp_id    = '0;
    mem_resp_data  = '0;
    step();
  endtask

  initial begin
    reset_n        = 1'b0;
    b_valid        = '0;
    b_wr           = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_id    = '0;
    mem_resp_data  = '0;
    for (int i = 0; i < 3; i++) begin
      b_addr[i]  = '0;
      b_wdata[i] = '0;
    end

    // All three requesters valid from reset: rotation fetch, load, store, fetch.
    b_addr[0] = 64'h100;
    b_addr[1] = 64'h20F;
    b_addr[2] = 64'h300;
    b_wdata[2] = 64'hCAFE;
    b_wr[2]   = 1'b1;
    b_valid   = 3'b111;
    step();
    step();
    @(negedge clk);
    check_zero("reset");
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_grant(3'b001 << (k % 3), "rr_grant");
      step();
      if (k == 3) b_valid = 3'b000;
      mem_serve(0, 0, 1'b0, 4'(1 + k % 3), 64'hA000 + 64'(k), 3'b001 << (k % 3));
    end

    // Fetch-only read with unaligned address.
    b_addr[0] = 64'h1004;
    b_valid   = 3'b001;
    wait_grant(3'b001, "fetch_grant");
    step();
    b_valid = 3'b000;
    mem_serve(0, 1, 1'b0, 4'd1, 64'hDEADBEEF_00000013, 3'b001);
    @(negedge clk);
    chk("fetch_perr", protocol_err, 0);
    step();

    // Store with memory stalling for 5 cycles.
    b_addr[2]  = 64'h2000;
    b_wdata[2] = 64'h55;
    b_valid    = 3'b100;
    wait_grant(3'b100, "store_grant");
    step();
    b_valid = 3'b000;
    mem_serve(5, 0, 1'b0, 4'd3, 64'h0A0A, 3'b100);

    // Load sees a wrong-ID response before its own.
    b_addr[1] = 64'h3008;
    b_valid   = 3'b010;
    wait_grant(3'b010, "load_grant");
    step();
    b_valid = 3'b000;
    mem_serve(0, 0, 1'b1, 4'd2, 64'h12345678_9ABCDEF0, 3'b010);

    // Reset while waiting on memory, then a late response.
    b_addr[2]  = 64'h4000;
    b_wdata[2] = 64'h77;
    b_valid    = 3'b100;
    wait_grant(3'b100, "rst_store_grant");
    step();
    b_valid       = 3'b000;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    reset_n       = 1'b0;
    @(negedge clk);
    check_zero("mid_reset");
    step();
    reset_n = 1'b1;
    step();
    step();
    mem_resp_valid = 1'b1;
    mem_resp_id    = 4'd3;
    mem_resp_data  = 64'hBAD;
    step();
    mem_resp_valid = 1'b0;
    mem_resp_id    = '0;
    mem_resp_data  = '0;
    @(negedge clk);
    chk("late_resp_perr", protocol_err, 1);
    step();

    // Pointer restarts at fetch: fetch beats store, store then waits 4 cycles.
    b_addr[0]  = 64'h5000;
    b_addr[2]  = 64'h6008;
    b_wdata[2] = 64'h99;
    b_valid    = 3'b101;
    wait_grant(3'b001, "rr_after_reset");
    step();
    b_valid[0] = 1'b0;
    mem_serve(0, 0, 1'b0, 4'd1, 64'h5555, 3'b001);
    wait_grant(3'b100, "store_after_fetch");
    chk("stat_store", 64'(stat_wait_cnt[95:64]), STATS ? 64'd4 : 64'd0);
    step();
    b_valid[2] = 1'b0;
    mem_serve(0, 0, 1'b0, 4'd3, 64'h66, 3'b100);

    // Load held valid 7 cycles behind a slow fetch.
    b_addr[0] = 64'h7000;
    b_addr[1] = 64'h8000;
    b_valid   = 3'b011;
    wait_grant(3'b001, "stats_fetch");
    step();
    b_valid[0] = 1'b0;
    mem_serve(0, 3, 1'b0, 4'd1, 64'h77, 3'b001);
    wait_grant(3'b010, "stats_load_grant");
    chk("stat_load", 64'(stat_wait_cnt[63:32]), STATS ? 64'd7 : 64'd0);
    step();
    b_valid[1] = 1'b0;
    mem_serve(0, 0, 1'b0, 4'd2, 64'h88, 3'b010);

    step();
    chk("mem_q_empty", 64'(exp_mem.size()), 0);
    chk("resp_q_empty", 64'(exp_resp.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
